// File: rtl/m_divide_subtractor_pkg.sv
// m_divide_subtractor_pkg
//   Shared definitions for the divide-subtractor slice.
//   - state_t : controller states (IDLE/SUB/DIV/DONE)
//   - DIVISOR : constant divisor of the restoring divide
//   - W_Y_DEF / W_B_DEF : default datapath / recovered-operand widths
package m_divide_subtractor_pkg;

  localparam int unsigned W_Y_DEF = 32;
  localparam int unsigned W_B_DEF = 16;
  localparam int unsigned DIVISOR = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SUB,
    ST_DIV,
    ST_DONE
  } state_t;

endpackage

// File: rtl/m_div3_step.sv
// m_div3_step
//   One combinational step of a restoring divide by DIVISOR (3).
//   Ports:
//     w_rem_in  [1:0] : partial remainder entering the step (always < 3)
//     w_bit           : next dividend bit, MSB first
//     w_q_bit         : quotient bit produced by this step
//     w_rem_out [1:0] : partial remainder leaving the step
module m_div3_step
  import m_divide_subtractor_pkg::*;
(
  input  logic [1:0] w_rem_in,
  input  logic       w_bit,
  output logic       w_q_bit,
  output logic [1:0] w_rem_out
);

  logic [2:0] t;

  // The incoming remainder is below 3, so t <= 5 and t - 3 always fits in 2 bits.
  always_comb begin
    t = {w_rem_in, w_bit};
    if (t >= 3'(DIVISOR)) begin
      w_q_bit   = 1'b1;
      w_rem_out = 2'(t - 3'(DIVISOR));
    end else begin
      w_q_bit   = 1'b0;
      w_rem_out = t[1:0];
    end
  end

endmodule

// File: rtl/m_divide_subtractor.sv
// m_divide_subtractor
//   Recovers the multiplicand of the multiply-adder: b = (y - c) / 3 and the
//   remainder, using an iterative restoring divide-by-3 (one quotient bit per
//   cycle) with valid/ready handshakes on input and output.
//   Optional feature macro: M_DIVIDE_SUBTRACTOR_CHECK_EN
//     defined   : r_err = underflow | quotient wider than W_B | remainder != 0
//     undefined : r_err tied low, check logic not built
//   Ports:
//     w_clock        : clock, rising edge
//     w_reset        : synchronous active-high reset
//     w_valid        : request valid (ignored while r_ready is low)
//     w_y   [W_Y-1:0]: multiply-adder result
//     w_c   [W_Y-1:0]: addend
//     r_ready        : block can accept a request
//     r_valid        : result available, held until w_ack
//     w_ack          : consumer takes the result
//     r_b   [W_B-1:0]: recovered operand (low W_B quotient bits)
//     r_rem [1:0]    : remainder of (y - c) mod 3
//     r_err          : consistency error
module m_divide_subtractor
  import m_divide_subtractor_pkg::*;
#(
  parameter int unsigned W_Y = W_Y_DEF,
  parameter int unsigned W_B = W_B_DEF
) (
  input  logic           w_clock,
  input  logic           w_reset,
  input  logic           w_valid,
  input  logic [W_Y-1:0] w_y,
  input  logic [W_Y-1:0] w_c,
  output logic           r_ready,
  output logic           r_valid,
  input  logic           w_ack,
  output logic [W_B-1:0] r_b,
  output logic [1:0]     r_rem,
  output logic           r_err
);

  localparam int unsigned W_CNT = (W_Y > 1) ? $clog2(W_Y) : 1;

  // Without the check only the bits that reach r_b are worth keeping.
`ifdef M_DIVIDE_SUBTRACTOR_CHECK_EN
  localparam int unsigned W_Q = W_Y;
`else
  localparam int unsigned W_Q = W_B;
`endif

  state_t           state;
  state_t           state_nxt;
  logic [W_Y-1:0]   y_reg;
  logic [W_Y-1:0]   c_reg;
  logic [W_Y-1:0]   diff;
  logic [W_Q-1:0]   quot;
  logic [W_Q-1:0]   quot_upd;
  logic [1:0]       rem;
  logic [1:0]       rem_step;
  logic [W_CNT-1:0] cnt;
  logic             dbit;
  logic             q_bit;
  logic             accept;
  logic             last_step;
  logic             release_out;

`ifdef M_DIVIDE_SUBTRACTOR_CHECK_EN
  logic             under;
`endif

  m_div3_step u_step (
    .w_rem_in  (rem),
    .w_bit     (dbit),
    .w_q_bit   (q_bit),
    .w_rem_out (rem_step)
  );

  // Bit selects by cnt are done as compare loops so the index width never
  // has to match the vector width exactly.
  always_comb begin
    dbit = 1'b0;
    for (int unsigned i = 0; i < W_Y; i++) begin
      if (cnt == W_CNT'(i)) dbit = diff[i];
    end
  end

  always_comb begin
    quot_upd = quot;
    for (int unsigned i = 0; i < W_Q; i++) begin
      if (cnt == W_CNT'(i)) quot_upd[i] = q_bit;
    end
  end

  // State register
  always_ff @(posedge w_clock) begin
    if (w_reset) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (w_valid && r_ready) state_nxt = ST_SUB;
      ST_SUB:  state_nxt = ST_DIV;
      ST_DIV:  if (cnt == '0) state_nxt = ST_DONE;
      ST_DONE: if (w_ack) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output/control decode
  always_comb begin
    accept      = (state == ST_IDLE) && w_valid && r_ready;
    last_step   = (state == ST_DIV) && (cnt == '0);
    release_out = (state == ST_DONE) && w_ack;
  end

  // Datapath and registered outputs
  always_ff @(posedge w_clock) begin
    if (w_reset) begin
      y_reg   <= '0;
      c_reg   <= '0;
      diff    <= '0;
      quot    <= '0;
      rem     <= '0;
      cnt     <= '0;
      r_ready <= 1'b1;
      r_valid <= 1'b0;
      r_b     <= '0;
      r_rem   <= '0;
`ifdef M_DIVIDE_SUBTRACTOR_CHECK_EN
      under   <= 1'b0;
      r_err   <= 1'b0;
`endif
    end else begin
      if (accept) begin
        y_reg   <= w_y;
        c_reg   <= w_c;
        r_ready <= 1'b0;
      end

      if (state == ST_SUB) begin
        diff <= y_reg - c_reg;
        quot <= '0;
        rem  <= '0;
        cnt  <= W_CNT'(W_Y - 1);
`ifdef M_DIVIDE_SUBTRACTOR_CHECK_EN
        under <= (y_reg < c_reg);
`endif
      end

      if (state == ST_DIV) begin
        quot <= quot_upd;
        rem  <= rem_step;
        if (cnt != '0) cnt <= cnt - 1'b1;
      end

      // Results are taken from the step outputs so they land on DONE entry.
      if (last_step) begin
        r_b     <= quot_upd[W_B-1:0];
        r_rem   <= rem_step;
        r_valid <= 1'b1;
`ifdef M_DIVIDE_SUBTRACTOR_CHECK_EN
        r_err   <= under | (quot_upd[W_Y-1:W_B] != '0) | (rem_step != 2'd0);
`endif
      end

      if (release_out) begin
        r_valid <= 1'b0;
        r_ready <= 1'b1;
      end
    end
  end

`ifndef M_DIVIDE_SUBTRACTOR_CHECK_EN
  assign r_err = 1'b0;
`endif

endmodule

// File: doc/m_divide_subtractor.md
# m_divide_subtractor

Inverse of the multiply-adder datapath: given a result `y` and the addend `c`, recovers the multiplicand as `b = (y - c) / 3` plus the remainder. It uses an iterative restoring divide-by-3, one quotient bit per cycle, with valid/ready handshakes on both sides. It sits downstream of `m_multiply_adder` in the checking path, feeding recovered operands back to the simulator for comparison.

## Interface
- `W_Y`, default 32: width of `y`, `c`, the difference and the internal quotient.
- `W_B`, default 16: width of the recovered operand output.
- `w_clock` in 1: the single clock, rising edge.
- `w_reset` in 1: synchronous, active-high reset.
- `w_valid` in 1: input request.
- `w_y` in W_Y: multiply-adder result.
- `w_c` in W_Y: addend.
- `r_ready` out 1: block can accept a request. Reset 1.
- `r_valid` out 1: result available. Reset 0.
- `w_ack` in 1: consumer takes the result.
- `r_b` out W_B: recovered operand. Reset 0.
- `r_rem` out 2: remainder of `(y - c) mod 3`. Reset 0.
- `r_err` out 1: consistency error. Reset 0.

## Operation
- States: IDLE, SUB, DIV, DONE. Reset enters IDLE.
- **IDLE.** `r_ready` = 1.
  - `w_valid` & `r_ready` at an edge: capture `w_y` and `w_c`, go to SUB, drop `r_ready`.
- **SUB.** `diff = y - c`, modulo 2^W_Y; wrap is permitted. Record `under = (y < c)`. Clear the partial remainder. Bit counter = W_Y-1. Go to DIV.
- **DIV.** Each cycle:
  - `t = {rem, diff[cnt]}` (3 bits).
  - If `t >= 3`: `q[cnt] = 1`, `rem = t - 3`. Else `q[cnt] = 0`, `rem = t`.
  - After the cnt==0 step, go to DONE.
- **DONE.**
  - Outputs update on entry: `r_b = q[W_B-1:0]`, `r_rem = rem`, `r_valid = 1`.
  - Outputs hold until `w_ack` is sampled high. Then go to IDLE: `r_valid` = 0, `r_ready` = 1.
  - `r_b` and `r_rem` keep their last value after the ack.
- `w_valid` is ignored while `r_ready` = 0. There is no queuing.
- `w_ack` outside DONE is ignored.
- `w_reset` has priority over all other inputs, including `w_valid` in the same cycle.
- Reset mid-SUB or mid-DIV: the operation is discarded, the block returns to IDLE and all outputs take their reset values.

## Timing
- Edge E0: input accepted.
- E1: SUB completes.
- E2..E(W_Y+1): W_Y DIV steps.
- `r_valid` is high after edge E(W_Y+1). That is 33 cycles for the default width.
- The earliest ack is at edge E(W_Y+2). The next accept is possible one edge after the ack edge.
- Minimum request-to-request spacing is W_Y+3 cycles, i.e. 35 for the default width.
- All outputs are registered. There are no combinational paths from input to output.

## Configuration
- `M_DIVIDE_SUBTRACTOR_CHECK_EN` defined:
  - `r_err = under | (q[W_Y-1:W_B] != 0) | (rem != 0)`.
  - Latched on DONE entry together with `r_b`.
- Macro undefined:
  - `r_err` is tied to 0.
  - `under` and the upper-quotient compare logic are not built.
  - `r_b` is still truncated to `q[W_B-1:0]`.

## Structure
- Package `m_divide_subtractor_pkg` holds:
  - the state enumeration (IDLE/SUB/DIV/DONE);
  - the constant DIVISOR = 3;
  - the default widths.
- Sub-module `m_div3_step` is combinational: 2-bit remainder in, 1 dividend bit in → quotient bit and 2-bit remainder out. It is instantiated once and used iteratively.

## Test plan
- `y`=5, `c`=2 → after 33 cycles `r_valid`; `r_b`=1, `r_rem`=0, `r_err`=0.
- Back-to-back requests (29,8), (17,6), (23,2), each acked on the first valid cycle → `r_b` = 7, 3, 7. `r_ready` is low throughout each operation; a `w_valid` pulse sent during DIV is dropped.
- `y`=10, `c`=0 → `r_b`=3, `r_rem`=1; `r_err`=1 with CHECK_EN, 0 without.
- Underflow: `y`=1, `c`=2 → diff 0xFFFFFFFF, `r_b`=0x5555, `r_rem`=0; `r_err`=1 with CHECK_EN.
- Quotient overflow: `y`=0x30000, `c`=0 → q=0x10000, `r_b`=0; `r_err`=1 with CHECK_EN.
- Reset at cycle 10 of DIV → next cycle IDLE, `r_ready`=1, `r_valid`=0, `r_b`/`r_rem`/`r_err` = 0. Reset asserted together with `w_valid` → request not accepted. Holding `w_ack` low for 5 cycles in DONE → outputs stable.
